// File: rtl/sum_bcd_display.sv
// Binary-to-BCD converter for the adder sum: sequential shift-add-3 (double dabble)
// with registered BCD and active-low seven-segment outputs, valid/ready in, done pulse out.
module sum_bcd_display #(
    parameter int WIDTH    = 5,
    parameter int DIGITS   = 2,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7*DIGITS-1:0]   hex,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic longint pow10_f(input int n);
        longint p;
        p = 64'sd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'sd10;
        end
        return p;
    endfunction

    // Every digit must fit the largest binary value, otherwise the top digit overflows.
    if (pow10_f(DIGITS) <= ((64'sd1 <<< WIDTH) - 64'sd1)) begin : g_param_check
        $error("sum_bcd_display: DIGITS too small for WIDTH");
    end

    function automatic logic [6:0] seg7_f(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    function automatic logic [7*DIGITS-1:0] hex_reset_f();
        logic [7*DIGITS-1:0] h;
        h = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == 0 || !BLANK_LZ) begin
                h[7*k +: 7] = 7'b1000000;
            end else begin
                h[7*k +: 7] = 7'b1111111;
            end
        end
        return h;
    endfunction

    localparam logic [7*DIGITS-1:0] HEX_RST = hex_reset_f();

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t                state_r;
    logic [WIDTH-1:0]      bin_r;
    logic [4*DIGITS-1:0]   work_r;
    logic [CW-1:0]         cnt_r;
    logic [4*DIGITS-1:0]   bcd_r;
    logic [7*DIGITS-1:0]   hex_r;
    logic                  done_r;

    logic [4*DIGITS-1:0]   adj_s;
    logic [7*DIGITS-1:0]   hex_next_s;
    logic                  seen_s;

    assign in_ready = (state_r == IDLE);
    assign hex      = hex_r;
    assign bcd      = bcd_r;
    assign done     = done_r;

    // Add-3 correction applied to each work nibble before the next shift.
    always_comb begin
        adj_s = work_r;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_r[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = work_r[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = work_r[4*k +: 4];
            end
        end
    end

    // Segment encoding of the finished work register; scanning from the top digit
    // tracks whether any non-zero digit has appeared yet for leading-zero blanking.
    always_comb begin
        hex_next_s = '1;
        seen_s     = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (work_r[4*k +: 4] != 4'd0) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
            if (BLANK_LZ && (k != 0) && !seen_s) begin
                hex_next_s[7*k +: 7] = 7'b1111111;
            end else begin
                hex_next_s[7*k +: 7] = seg7_f(work_r[4*k +: 4]);
            end
        end
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            bin_r   <= '0;
            work_r  <= '0;
            cnt_r   <= '0;
            bcd_r   <= '0;
            hex_r   <= HEX_RST;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        bin_r   <= in_value;
                        work_r  <= '0;
                        cnt_r   <= '0;
                        state_r <= CONVERT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONVERT: begin
                    {work_r, bin_r} <= {adj_s[4*DIGITS-2:0], bin_r, 1'b0};
                    cnt_r           <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= CONVERT;
                    end
                end
                LOAD: begin
                    bcd_r   <= work_r;
                    hex_r   <= hex_next_s;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Randomized self-checking bench for sum_bcd_display; expected digits come from
// decimal arithmetic (v/10^k mod 10) and a segment lookup table.
module tb_sum_bcd_display;

    localparam int WIDTH  = 5;
    localparam int DIGITS = 2;

    logic                clk;
    logic                reset_n;
    logic [WIDTH-1:0]    in_value;
    logic                in_valid;
    logic                in_ready, in_ready_b;
    logic [7*DIGITS-1:0] hex, hex_b;
    logic [4*DIGITS-1:0] bcd, bcd_b;
    logic                done, done_b;

    int checks;
    int errors;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    sum_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .in_value(in_value), .in_valid(in_valid),
        .in_ready(in_ready), .hex(hex), .bcd(bcd), .done(done)
    );

    sum_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .in_value(in_value), .in_valid(in_valid),
        .in_ready(in_ready_b), .hex(hex_b), .bcd(bcd_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7*DIGITS-1:0] exp_hex(input int v, input bit blank);
        logic [7*DIGITS-1:0] h;
        for (int k = 0; k < DIGITS; k++) begin
            if (blank && k > 0 && v < pow10(k)) h[7*k +: 7] = 7'b1111111;
            else                                h[7*k +: 7] = seg_tab[(v / pow10(k)) % 10];
        end
        return h;
    endfunction

    function automatic logic [4*DIGITS-1:0] exp_bcd(input int v);
        logic [4*DIGITS-1:0] b;
        for (int k = 0; k < DIGITS; k++) b[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done, bounded; returns number of edges waited (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_outputs(input int v);
        check_eq("bcd", 32'(bcd), 32'(exp_bcd(v)));
        check_eq("hex", 32'(hex), 32'(exp_hex(v, 1'b1)));
        check_eq("bcd_nb", 32'(bcd_b), 32'(exp_bcd(v)));
        check_eq("hex_nb", 32'(hex_b), 32'(exp_hex(v, 1'b0)));
        check_eq("done_nb", 32'(done_b), 32'd1);
    endtask

    task automatic do_conv(input int v, input int gap);
        int lat;
        repeat (gap) step();
        check_eq("ready_idle", 32'(in_ready), 32'd1);
        in_value = WIDTH'(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_value = WIDTH'($urandom);
        check_eq("ready_busy", 32'(in_ready), 32'd0);
        wait_done(lat);
        check_eq("latency", 32'(lat), 32'(WIDTH + 1));
        check_eq("ready_at_done", 32'(in_ready), 32'd1);
        check_outputs(v);
        step();
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("hex_hold", 32'(hex), 32'(exp_hex(v, 1'b1)));
    endtask

    logic [7*DIGITS-1:0] hex_rst;

    initial begin
        int lat, lat2, v;
        checks   = 0;
        errors   = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        hex_rst  = {7'b1111111, 7'b1000000};

        // Reset state
        repeat (3) step();
        check_eq("rst_hex", 32'(hex), 32'(hex_rst));
        check_eq("rst_hex_nb", 32'(hex_b), 32'(exp_hex(0, 1'b0)));
        check_eq("rst_bcd", 32'(bcd), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        step();
        check_eq("rel_hex", 32'(hex), 32'(hex_rst));
        check_eq("rel_bcd", 32'(bcd), 32'd0);
        check_eq("rel_done", 32'(done), 32'd0);

        // Directed values: max, single digit, boundary, zero
        do_conv(31, 0);
        do_conv(9, 1);
        do_conv(10, 0);
        do_conv(0, 2);

        // Busy ignore: second value held on in_valid during CONVERT
        in_value = WIDTH'(17);
        in_valid = 1'b1;
        step();
        in_value = WIDTH'(22);
        wait_done(lat);
        check_eq("busy_first", 32'(bcd), 32'(exp_bcd(17)));
        wait_done(lat2);
        in_valid = 1'b0;
        check_eq("busy_second", 32'(bcd), 32'(exp_bcd(22)));
        check_eq("busy_hex", 32'(hex), 32'(exp_hex(22, 1'b1)));
        check_eq("busy_spacing", 32'(lat2), 32'(WIDTH + 2));
        step();

        // Reset mid-conversion
        in_value = WIDTH'(25);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_hex", 32'(hex), 32'(hex_rst));
        check_eq("mid_rst_bcd", 32'(bcd), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        lat = 0;
        repeat (3) begin
            step();
            if (done) lat++;
        end
        reset_n = 1'b1;
        repeat (8) begin
            step();
            if (done) lat++;
        end
        check_eq("mid_rst_no_done", 32'(lat), 32'd0);
        check_eq("mid_rst_bcd_after", 32'(bcd), 32'd0);
        do_conv(5, 0);

        // Randomized values with random idle gaps
        for (int n = 0; n < 30; n++) begin
            v = int'($urandom_range(31, 0));
            do_conv(v, int'($urandom_range(3, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_bcd_display.md
Name: sum_bcd_display

Overview:
- Downstream consumer of the 4-bit ripple-carry adder result (5-bit sum incl. carry-out).
- Converts the binary sum to decimal with a sequential shift-add-3 (double-dabble) FSM.
- Drives active-low seven-segment digits for the HEX displays.
- Uses a valid/ready handshake on input and a one-cycle done pulse on output.

Parameters:
- WIDTH, 5, bit width of binary input value.
- DIGITS, 2, number of decimal digits/displays driven. Must satisfy 10^DIGITS > 2^WIDTH-1; elaboration error otherwise.
- BLANK_LZ, 1, 1 = blank leading-zero digits (digit 0 never blanked); 0 = show all zeros.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_value  input  WIDTH  binary sum from adder.
- in_valid  input  1  in_value valid this cycle.
- in_ready  output  1  block can accept a value (high only in IDLE).
- hex  output  7*DIGITS  active-low segments; digit k in bits [7k+6:7k], bit order g..a = bit6..bit0; digit 0 = units.
- bcd  output  4*DIGITS  registered BCD of last completed conversion; digit k in bits [4k+3:4k].
- done  output  1  one-cycle pulse when hex/bcd update.

Behaviour:
- Clock is clk; reset is reset_n, asynchronous and active-low.
- Reset values:
  - state = IDLE; done = 0; bcd = 0.
  - hex digit 0 = 7'b1000000 ("0").
  - Higher digits = 7'b1111111 if BLANK_LZ, else 7'b1000000.
  - Internal shift register and counter = 0.
- in_ready is combinational: 1 iff state == IDLE, including while reset_n is low.
- IDLE:
  - On in_valid && in_ready at edge N: latch in_value into the shift register, clear the BCD work register and counter, go to CONVERT.
  - in_valid with in_ready low is ignored (no queuing).
- CONVERT, one bit per cycle:
  - Add 3 to every BCD work nibble >= 5.
  - Then shift {bcd_work, bin} left 1.
  - Increment counter.
  - After WIDTH shifts (counter == WIDTH-1 on the shift), go to LOAD.
- LOAD (one cycle):
  - Copy bcd_work to bcd.
  - Encode each nibble to segments and register into hex.
  - Assert done for exactly this one cycle.
  - Return to IDLE.
- Latency: value accepted at edge N; hex/bcd/done visible after edge N+WIDTH+1. in_ready returns high the same cycle done is high, so the next accept can occur at edge N+WIDTH+2. Throughput: 1 value per WIDTH+2 cycles.
- Segment map, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble > 9 is unreachable; encode as 1111111.
- Leading-zero blanking (BLANK_LZ = 1): digit k > 0 is blanked iff it and all higher digits are 0. Digit 0 always shows.
- hex and bcd hold their value between conversions. in_value changes outside the accept cycle have no effect.
- Reset mid-conversion: immediate return to reset values. The in-flight conversion is discarded and no done pulse is issued.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles -> hex = {1111111,1000000}, bcd = 0, done = 0, in_ready = 1. Release -> values unchanged.
- Max value: in_value = 31, one-cycle valid at edge N -> at N+6: bcd = 8'h31, hex[6:0] = 1111001, hex[13:7] = 0110000, done = 1 for one cycle.
- Single digit: in_value = 9 -> bcd = 8'h09, hex[6:0] = 0010000, hex[13:7] = 1111111 (blanked). Repeat with BLANK_LZ = 0 -> hex[13:7] = 1000000.
- Boundary and zero: in_value = 10 -> hex = {1111001,1000000}. in_value = 0 -> hex = {1111111,1000000}.
- Busy ignore: accept 17, then hold in_valid=1 with in_value = 22 during CONVERT -> first done shows 17. The next accept occurs at the first IDLE cycle; second done shows 22 exactly WIDTH+2 cycles after the first done.
- Reset mid-operation: accept 25, drop reset_n 3 cycles later -> outputs at reset values, no done pulse. After release, accept 5 -> hex[6:0] = 0010010, done pulses once.
